// File: rtl/fpga_clk_div_cfg_pkg.sv
// rtl/fpga_clk_div_cfg_pkg.sv - shared address map, lock states and request struct for the clock divider block
// Optional PERF counter is selected with FPGA_CLK_DIV_CFG_PERF_EN.
package fpga_clk_div_cfg_pkg;

    localparam logic [4:0] ADDR_CTRL   = 5'd0;
    localparam logic [4:0] ADDR_DIV    = 5'd1;
    localparam logic [4:0] ADDR_STATUS = 5'd2;
    localparam logic [4:0] ADDR_ID     = 5'd3;
    localparam logic [4:0] ADDR_PERF   = 5'd4;

    // Channel c reports CH_ID_BASE + (c << ID_SHIFT) from its ID register.
    localparam int ID_SHIFT = 16;

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    typedef struct packed {
        logic [4:0]  add;
        logic [31:0] data;
        logic        wrn;
    } cfg_req_t;

endpackage

// File: rtl/fpga_clk_div_ch.sv
// rtl/fpga_clk_div_ch.sv - one channel: config registers, integer divider, settle/lock FSM
// PERF counter present only when FPGA_CLK_DIV_CFG_PERF_EN is defined.
module fpga_clk_div_ch
    import fpga_clk_div_cfg_pkg::*;
#(
    parameter int          DIV_WIDTH   = 8,
    parameter int          DIV_RST     = 1,
    parameter int          LOCK_CYCLES = 16,
    parameter logic [31:0] CH_ID       = 32'h0001_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  cfg_req_t    cfg_i,
    output logic        ack_o,
    output logic [31:0] r_data_o,
    output logic        lock_o,
    output logic        clk_en_o
);

    localparam int                   SW          = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [SW-1:0]        SETTLE_LAST = SW'(LOCK_CYCLES - 1);
    localparam logic [SW-1:0]        SETTLE_ONE  = SW'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE     = DIV_WIDTH'(1);

    lock_state_e          state_q, state_d;
    logic                 ack_q;
    logic [31:0]          r_data_q, r_data_d;
    logic                 en_q;
    logic [DIV_WIDTH-1:0] div_q, div_cnt_q;
    logic [SW-1:0]        settle_cnt_q;
    logic                 sample, wr, restart, settle_done, settling, div_hit;
    logic [31:0]          perf_val;
    logic                 unused_data;

    assign sample      = req_i & ~ack_q;
    assign wr          = sample & ~cfg_i.wrn;
    // Any DIV write, or re-enabling a disabled channel, forces a fresh settle period.
    assign restart     = wr & ((cfg_i.add == ADDR_DIV) |
                               ((cfg_i.add == ADDR_CTRL) & cfg_i.data[0] & ~en_q));
    assign settle_done = (settle_cnt_q == SETTLE_LAST);
    assign div_hit     = (div_q <= DIV_ONE) | (div_cnt_q == div_q - DIV_ONE);
    assign unused_data = ^cfg_i.data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= SETTLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (restart)                                  state_d = SETTLE;
        else if (state_q == SETTLE && settle_done)    state_d = LOCKED;
    end

    always_comb begin
        lock_o   = (state_q == LOCKED);
        settling = (state_q == SETTLE);
        clk_en_o = lock_o & en_q & div_hit;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            settle_cnt_q <= '0;
            div_cnt_q    <= '0;
        end else begin
            if (restart || state_q != SETTLE || settle_done) settle_cnt_q <= '0;
            else                                             settle_cnt_q <= settle_cnt_q + SETTLE_ONE;
            if (restart || !lock_o || !en_q || div_q <= DIV_ONE || div_hit) div_cnt_q <= '0;
            else                                                          div_cnt_q <= div_cnt_q + DIV_ONE;
        end
    end

    always_comb begin
        r_data_d = '0;
        if (sample && cfg_i.wrn) begin
            case (cfg_i.add)
                ADDR_CTRL:   r_data_d = {31'd0, en_q};
                ADDR_DIV:    r_data_d = 32'(div_q);
                ADDR_STATUS: r_data_d = {30'd0, settling, lock_o};
                ADDR_ID:     r_data_d = CH_ID;
                ADDR_PERF:   r_data_d = perf_val;
                default:     r_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q    <= 1'b0;
            r_data_q <= '0;
            en_q     <= 1'b1;
            div_q    <= DIV_WIDTH'(DIV_RST);
        end else begin
            ack_q    <= sample;
            r_data_q <= r_data_d;
            if (wr && cfg_i.add == ADDR_CTRL) en_q  <= cfg_i.data[0];
            if (wr && cfg_i.add == ADDR_DIV)  div_q <= cfg_i.data[DIV_WIDTH-1:0];
        end
    end

`ifdef FPGA_CLK_DIV_CFG_PERF_EN
    logic [31:0] perf_q;

    // Clear on write wins over a coincident increment; SETTLE does not touch it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                          perf_q <= '0;
        else if (wr && cfg_i.add == ADDR_PERF) perf_q <= '0;
        else if (clk_en_o)                    perf_q <= perf_q + 32'd1;
    end

    assign perf_val = perf_q;
`else
    assign perf_val = '0;
`endif

    assign ack_o    = ack_q;
    assign r_data_o = r_data_q;

endmodule

// File: rtl/fpga_clk_div_cfg.sv
// rtl/fpga_clk_div_cfg.sv - N_CH independent configurable clock-enable dividers with lock indication
// Optional per-channel PERF counter enabled by FPGA_CLK_DIV_CFG_PERF_EN.
module fpga_clk_div_cfg
    import fpga_clk_div_cfg_pkg::*;
#(
    parameter int          N_CH        = 3,
    parameter int          DIV_WIDTH   = 8,
    parameter int          DIV_RST     = 1,
    parameter int          LOCK_CYCLES = 16,
    parameter logic [31:0] CH_ID_BASE  = 32'h0001_0000
) (
    input  logic              ref_clk_i,
    input  logic              rstn_glob_i,
    input  logic [N_CH-1:0]   cfg_req_i,
    output logic [N_CH-1:0]   cfg_ack_o,
    input  logic [N_CH*5-1:0] cfg_add_i,
    input  logic [N_CH*32-1:0] cfg_data_i,
    input  logic [N_CH-1:0]   cfg_wrn_i,
    output logic [N_CH*32-1:0] cfg_r_data_o,
    output logic [N_CH-1:0]   cfg_lock_o,
    output logic [N_CH-1:0]   clk_en_o
);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        cfg_req_t ch_req;

        assign ch_req.add  = cfg_add_i[c*5 +: 5];
        assign ch_req.data = cfg_data_i[c*32 +: 32];
        assign ch_req.wrn  = cfg_wrn_i[c];

        fpga_clk_div_ch #(
            .DIV_WIDTH   (DIV_WIDTH),
            .DIV_RST     (DIV_RST),
            .LOCK_CYCLES (LOCK_CYCLES),
            .CH_ID       (CH_ID_BASE + (32'(c) << ID_SHIFT))
        ) u_ch (
            .clk_i    (ref_clk_i),
            .rst_ni   (rstn_glob_i),
            .req_i    (cfg_req_i[c]),
            .cfg_i    (ch_req),
            .ack_o    (cfg_ack_o[c]),
            .r_data_o (cfg_r_data_o[c*32 +: 32]),
            .lock_o   (cfg_lock_o[c]),
            .clk_en_o (clk_en_o[c])
        );
    end

endmodule
